// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port data memory.
// Optional bus lock for the last owner is enabled with DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    input  logic              lock0,
    input  logic              lock1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data_read
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            r_state;
    logic              r_last;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_mem_write;
    logic              r_mem_read;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata;

    logic              w_any;
    logic              w_lock_win;
    logic              w_pick;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

`ifdef DMEM_ARB_LOCK_EN
    // Last owner keeps the bus while it holds both lock and req.
    assign w_lock_win = r_last ? (req1 && lock1) : (req0 && lock0);
`else
    logic w_unused_lock;
    assign w_unused_lock = lock0 ^ lock1;
    assign w_lock_win    = 1'b0;
`endif

    assign w_any   = req0 | req1;
    assign w_pick  = w_lock_win      ? r_last :
                     (req0 && req1) ? ~r_last : req1;
    assign w_we    = w_pick ? we1    : we0;
    assign w_addr  = w_pick ? addr1  : addr0;
    assign w_wdata = w_pick ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= ACCESS;
                        r_owner     <= w_pick;
                        r_last      <= w_pick;
                        r_we        <= w_we;
                        r_addr      <= w_addr;
                        r_wdata     <= w_wdata;
                        r_gnt0      <= ~w_pick;
                        r_gnt1      <= w_pick;
                        r_mem_write <= w_we;
                        r_mem_read  <= ~w_we;
                    end
                end
                ACCESS: begin
                    r_state     <= IDLE;
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_mem_read  <= 1'b0;
                    if (!r_we) begin
                        r_rdata   <= mem_data_read;
                        r_rvalid0 <= ~r_owner;
                        r_rvalid1 <= r_owner;
                    end
                end
            endcase
        end
    end

    assign gnt0           = r_gnt0;
    assign gnt1           = r_gnt1;
    assign rvalid0        = r_rvalid0;
    assign rvalid1        = r_rvalid1;
    assign rdata          = r_rdata;
    assign mem_address    = r_addr;
    assign mem_data_write = r_wdata;
    assign mem_write      = r_mem_write;
    assign mem_read       = r_mem_read;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_write;
    logic          mem_write, mem_read;
    logic [DW-1:0] mem_data_read;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .lock0(lock0), .lock1(lock1),
        .mem_address(mem_address), .mem_data_write(mem_data_write),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_data_read(mem_data_read)
    );

    // Backdoor preload port shared by the memory and the model.
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a  = '0;
    logic [DW-1:0] pre_d  = '0;

    logic [DW-1:0] mem [0:65535];
    assign mem_data_read = mem[mem_address];
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_write) mem[mem_address] <= mem_data_write;
    end

    // Reference model: one pending transaction, decided from the spec rules.
    logic          m_acc, m_owner, m_we, m_last, m_rv0, m_rv1;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [DW-1:0] mm [0:65535];

    function automatic logic pick();
        logic p;
        if (req0 && req1) p = ~m_last;
        else              p = req1;
`ifdef DMEM_ARB_LOCK_EN
        if (m_last == 1'b0 && req0 && lock0) p = 1'b0;
        if (m_last == 1'b1 && req1 && lock1) p = 1'b1;
`endif
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc   <= 1'b0;
            m_owner <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_last  <= 1'b1;
            m_rv0   <= 1'b0;
            m_rv1   <= 1'b0;
            m_rdata <= '0;
        end else begin
            m_rv0 <= m_acc && !m_we && !m_owner;
            m_rv1 <= m_acc && !m_we &&  m_owner;
            if (m_acc && !m_we) m_rdata <= mm[m_addr];
            if (m_acc) begin
                m_acc <= 1'b0;
            end else if (req0 || req1) begin
                m_acc   <= 1'b1;
                m_owner <= pick();
                m_last  <= pick();
                m_we    <= pick() ? we1 : we0;
                m_addr  <= pick() ? addr1 : addr0;
                m_wdata <= pick() ? wdata1 : wdata0;
            end
        end
    end

    always @(posedge clk) begin
        if (pre_we) mm[pre_a] <= pre_d;
        else if (rst_n && m_acc && m_we) mm[m_addr] <= m_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic drop_all();
        req0 = 1'b0;
        req1 = 1'b0;
        lock0 = 1'b0;
        lock1 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_read} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected 000000",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_read});
        end
        n_tests++;
        if ({rdata, mem_address, mem_data_write} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {rdata, mem_address, mem_data_write});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'h0;
        tick();
        req0 = 1'b0;
        n_tests++;
        if ({gnt0, gnt1, mem_read, mem_write} !== 4'b1010) begin
            n_fail++;
            $display("FAIL read_gnt: got %b expected 1010",
                     {gnt0, gnt1, mem_read, mem_write});
        end
        n_tests++;
        if (mem_address !== 16'h0010) begin
            n_fail++;
            $display("FAIL read_addr: got %h expected 0010", mem_address);
        end
        tick();
        n_tests++;
        if ({rvalid0, rvalid1, gnt0, rdata} !== {3'b100, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL read_rvalid: got %b %h expected 100 beef",
                     {rvalid0, rvalid1, gnt0}, rdata);
        end
        tick();
        n_tests++;
        if ({rvalid0, rdata} !== {1'b0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL read_hold: got %b %h expected 0 beef", rvalid0, rdata);
        end
    endtask

    task automatic test_write_read();
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0004; wdata1 = 16'h1234;
        tick();
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0004;
        n_tests++;
        if ({gnt0, gnt1, mem_write, mem_read, mem_data_write} !==
            {4'b0110, 16'h1234}) begin
            n_fail++;
            $display("FAIL wr_gnt: got %b %h expected 0110 1234",
                     {gnt0, gnt1, mem_write, mem_read}, mem_data_write);
        end
        tick();
        n_tests++;
        if ({gnt0, gnt1, mem_write, mem_read} !== 4'b0000) begin
            n_fail++;
            $display("FAIL wr_idle: got %b expected 0000",
                     {gnt0, gnt1, mem_write, mem_read});
        end
        tick();
        req0 = 1'b0;
        n_tests++;
        if ({gnt0, mem_write, mem_read} !== 3'b101) begin
            n_fail++;
            $display("FAIL rd_gnt: got %b expected 101", {gnt0, mem_write, mem_read});
        end
        tick();
        n_tests++;
        if ({rvalid0, rdata} !== {1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL rd_data: got %b %h expected 1 1234", rvalid0, rdata);
        end
        drop_all();
    endtask

    task automatic test_alternate();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (c == 15) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            n_tests++;
            if ({gnt0, gnt1} !== {c % 4 == 0, c % 4 == 2}) begin
                n_fail++;
                $display("FAIL alt_c%0d: got %b%b expected %b%b", c, gnt0, gnt1,
                         c % 4 == 0, c % 4 == 2);
            end
        end
        drop_all();
    endtask

    task automatic test_reset_mid_access();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h5555;
        tick();
        req0 = 1'b0;
        n_tests++;
        if (mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got %b expected 1", mem_write);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_read, rdata,
             mem_address, mem_data_write} !== 54'h0) begin
            n_fail++;
            $display("FAIL rst_mid_out: got %b %h %h %h expected all 0",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_read},
                     rdata, mem_address, mem_data_write);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({rvalid0, rvalid1, mem_write} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_rv: got %b expected 000",
                     {rvalid0, rvalid1, mem_write});
        end
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0030;
        tick();
        req1 = 1'b0;
        n_tests++;
        if ({gnt0, gnt1, mem_read} !== 3'b011) begin
            n_fail++;
            $display("FAIL rst_mid_gnt: got %b expected 011", {gnt0, gnt1, mem_read});
        end
        tick();
        n_tests++;
        if ({rvalid1, rdata} !== {1'b1, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL rst_mid_rd: got %b %h expected 1 aaaa", rvalid1, rdata);
        end
        drop_all();
    endtask

    task automatic test_addr_change();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
        tick();
        req0 = 1'b0;
        addr0 = 16'h0020;
        #2;
        n_tests++;
        if ({gnt0, mem_address} !== {1'b1, 16'h0010}) begin
            n_fail++;
            $display("FAIL addr_hold: got %b %h expected 1 0010", gnt0, mem_address);
        end
        tick();
        n_tests++;
        if ({rvalid0, rdata} !== {1'b1, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL addr_data: got %b %h expected 1 beef", rvalid0, rdata);
        end
        drop_all();
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        lock0 = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0003;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0005;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 4) lock0 = 1'b0;
            if (c == 6) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            n_tests++;
            if ({gnt0, gnt1} !== {c == 0 || c == 2 || c == 4, c == 6}) begin
                n_fail++;
                $display("FAIL lock_c%0d: got %b%b expected %b%b", c, gnt0, gnt1,
                         c == 0 || c == 2 || c == 4, c == 6);
            end
        end
        drop_all();
    endtask
`endif

    task automatic test_random();
        int w0 = 0;
        int w1 = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            n_tests++;
            if ({gnt0, gnt1, mem_write, mem_read, rvalid0, rvalid1} !==
                {m_acc && !m_owner, m_acc && m_owner, m_acc && m_we,
                 m_acc && !m_we, m_rv0, m_rv1}) begin
                n_fail++;
                $display("FAIL rnd_ctl@%0d: got %b expected %b", i,
                         {gnt0, gnt1, mem_write, mem_read, rvalid0, rvalid1},
                         {m_acc && !m_owner, m_acc && m_owner, m_acc && m_we,
                          m_acc && !m_we, m_rv0, m_rv1});
            end
            n_tests++;
            if (rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL rnd_rdata@%0d: got %h expected %h", i, rdata, m_rdata);
            end
            if (m_acc) begin
                n_tests++;
                if ({mem_address, mem_data_write} !== {m_addr, m_wdata}) begin
                    n_fail++;
                    $display("FAIL rnd_bus@%0d: got %h %h expected %h %h", i,
                             mem_address, mem_data_write, m_addr, m_wdata);
                end
            end
            if (req0 && !gnt0) w0++;
            else w0 = 0;
            if (req1 && !gnt1) w1++;
            else w1 = 0;
            n_tests++;
            if (w0 > 3 || w1 > 3) begin
                n_fail++;
                $display("FAIL rnd_wait@%0d: got %0d/%0d expected <=3", i, w0, w1);
            end
            if ((req0 && gnt0 && $urandom_range(1, 0) == 1) ||
                (!req0 && $urandom_range(2, 0) == 0)) begin
                req0 = 1'b1; we0 = 1'($urandom_range(1, 0));
                addr0 = 16'($urandom_range(15, 0)); wdata0 = 16'($urandom);
            end else if (req0 && gnt0) begin
                req0 = 1'b0;
            end
            if ((req1 && gnt1 && $urandom_range(1, 0) == 1) ||
                (!req1 && $urandom_range(2, 0) == 0)) begin
                req1 = 1'b1; we1 = 1'($urandom_range(1, 0));
                addr1 = 16'($urandom_range(15, 0)); wdata1 = 16'($urandom);
            end else if (req1 && gnt1) begin
                req1 = 1'b0;
            end
        end
        drop_all();
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        lock0 = 1'b0; lock1 = 1'b0;
        for (int a = 0; a < 16; a++) preload(16'(a), 16'($urandom));
        preload(16'h0010, 16'hBEEF);
        preload(16'h0020, 16'h0BAD);
        preload(16'h0030, 16'hAAAA);
        test_reset();
        test_read();
        test_write_read();
        test_alternate();
        test_reset_mid_access();
        test_addr_change();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
